// File: rtl/decimal_key_encoder.sv
// Ten-line key encoder: synchronises and debounces raw key lines f0..f9, priority-encodes a
// single press to BCD (bit3=w .. bit0=z) and hands each press over once on valid/ready.
// Optional build macro: DECIMAL_KEY_MULTI_ERR_EN (multi-key presses raise err instead of
// emitting a code).
module decimal_key_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DB_W            = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] f_in,
    output logic [3:0] code_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StDebounce, StEmit, StRelease} state_e;

    // Terminal count shared by press acceptance and release qualification.
    localparam logic [DB_W-1:0] CntLast = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [9:0]      sync1_q, sync2_q;
    logic [9:0]      s;
    state_e          state_q, state_d;
    logic [9:0]      snap_q, snap_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic [3:0]      snap_code;
`ifdef DECIMAL_KEY_MULTI_ERR_EN
    logic            err_q, err_d;
`endif

    assign s = sync2_q;

    // Two-flop synchroniser on the raw key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= f_in;
            sync2_q <= sync1_q;
        end
    end

    // Lowest set key index wins; scanning downwards lets the lowest index overwrite last.
    always_comb begin
        snap_code = '0;
        for (int i = 9; i >= 0; i--) begin
            if (snap_q[i]) begin
                snap_code = 4'(i);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            snap_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
`ifdef DECIMAL_KEY_MULTI_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
`ifdef DECIMAL_KEY_MULTI_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic: debounce a press, emit it once, then wait for a clean release.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = valid_q;
`ifdef DECIMAL_KEY_MULTI_ERR_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (s != '0) begin
                    snap_d  = s;
                    cnt_d   = '0;
                    state_d = StDebounce;
                end
            end
            StDebounce: begin
                if (s == '0) begin
                    state_d = StIdle;
                end else if (s != snap_q) begin
                    // Pattern changed while bouncing: restart the stability window.
                    snap_d = s;
                    cnt_d  = '0;
                end else if (cnt_q == CntLast) begin
`ifdef DECIMAL_KEY_MULTI_ERR_EN
                    if ($countones(snap_q) > 1) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StRelease;
                    end else begin
                        code_d  = snap_code;
                        valid_d = 1'b1;
                        state_d = StEmit;
                    end
`else
                    code_d  = snap_code;
                    valid_d = 1'b1;
                    state_d = StEmit;
`endif
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            StEmit: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Held or new keys keep restarting the count, so there is no auto-repeat.
                if (s != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        busy     = (state_q != StIdle);
        code_out = code_q;
        valid    = valid_q;
`ifdef DECIMAL_KEY_MULTI_ERR_EN
        err      = err_q;
`else
        err      = 1'b0;
`endif
    end

endmodule

// File: tb/tb_decimal_key_encoder.sv
// Bench for decimal_key_encoder (DEBOUNCE_CYCLES=4): directed scenarios followed by random
// key traffic, all checked cycle by cycle against a run-length reference model.
module tb_decimal_key_encoder;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] f_in;
    logic [3:0] code_out;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    decimal_key_encoder #(
        .DEBOUNCE_CYCLES(DC),
        .DB_W           (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_in    (f_in),
        .code_out(code_out),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .err     (err)
    );

    // Reference model: a press is accepted once DC+1 consecutive identical non-zero samples are
    // seen while armed; it is re-armed only after DC consecutive all-zero samples post-handshake.
    typedef enum int {PhArmed, PhEmit, PhRelease} phase_e;

    phase_e     ph;
    logic [9:0] hist0, hist1;
    logic [9:0] run_val;
    int         run_len, zero_len;
    logic       m_valid, m_err;
    logic [3:0] m_code;

    int total = 0;
    int fails = 0;
    int edge_no, valid_cycles, err_cycles, first_valid_edge;

    function automatic logic [3:0] lowest_key(input logic [9:0] v);
        for (int i = 0; i < 10; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic int keys_down(input logic [9:0] v);
        int n = 0;
        for (int i = 0; i < 10; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        hist0    = '0;
        hist1    = '0;
        ph       = PhArmed;
        run_len  = 0;
        run_val  = '0;
        zero_len = 0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        m_code   = 4'd0;
    endtask

    task automatic model_edge();
        logic [9:0] s;
        s     = hist1;
        hist1 = hist0;
        hist0 = f_in;
        m_err = 1'b0;
        case (ph)
            PhArmed: begin
                if (s == '0) run_len = 0;
                else if (run_len > 0 && s == run_val) run_len++;
                else begin
                    run_len = 1;
                    run_val = s;
                end
                if (run_len == DC + 1) begin
                    run_len = 0;
`ifdef DECIMAL_KEY_MULTI_ERR_EN
                    if (keys_down(s) > 1) begin
                        m_err    = 1'b1;
                        ph       = PhRelease;
                        zero_len = 0;
                    end else begin
                        m_valid = 1'b1;
                        m_code  = lowest_key(s);
                        ph      = PhEmit;
                    end
`else
                    m_valid = 1'b1;
                    m_code  = lowest_key(s);
                    ph      = PhEmit;
`endif
                end
            end
            PhEmit: begin
                if (ready) begin
                    m_valid  = 1'b0;
                    ph       = PhRelease;
                    zero_len = 0;
                end
            end
            default: begin
                if (s == '0) zero_len++;
                else zero_len = 0;
                if (zero_len == DC) begin
                    ph      = PhArmed;
                    run_len = 0;
                end
            end
        endcase
    endtask

    task automatic check(input string tag);
        logic m_busy;
        m_busy = !(ph == PhArmed && run_len == 0);
        total++;
        assert (valid === m_valid) else begin
            fails++;
            $error("FAIL %s valid observed=%0b expected=%0b", tag, valid, m_valid);
        end
        total++;
        assert (code_out === m_code) else begin
            fails++;
            $error("FAIL %s code_out observed=%0d expected=%0d", tag, code_out, m_code);
        end
        total++;
        assert (busy === m_busy) else begin
            fails++;
            $error("FAIL %s busy observed=%0b expected=%0b", tag, busy, m_busy);
        end
        total++;
        assert (err === m_err) else begin
            fails++;
            $error("FAIL %s err observed=%0b expected=%0b", tag, err, m_err);
        end
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, sample +1.
    task automatic step(input logic [9:0] f, input logic r, input string tag);
        @(negedge clk);
        f_in  = f;
        ready = r;
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        check(tag);
        if (valid) valid_cycles++;
        if (err) err_cycles++;
        if (valid && first_valid_edge < 0) first_valid_edge = edge_no;
    endtask

    task automatic clear_counts();
        edge_no          = 0;
        valid_cycles     = 0;
        err_cycles       = 0;
        first_valid_edge = -1;
    endtask

    task automatic release_keys(input string tag);
        for (int i = 0; i < 8; i++) step(10'h000, 1'b1, tag);
    endtask

    initial begin
        logic [9:0] pat;
        logic [9:0] f;
        int         kind, hold;
        logic       bounce;

        rst_n = 1'b0;
        f_in  = '0;
        ready = 1'b0;
        model_reset();
        clear_counts();
        #1;
        check("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Key 3 with ready already high: one-cycle valid at edge 7.
        clear_counts();
        for (int i = 0; i < 10; i++) step(10'h008, 1'b1, "key3");
        total++;
        assert (first_valid_edge == 7) else begin
            fails++;
            $error("FAIL key3_latency observed=%0d expected=7", first_valid_edge);
        end
        total++;
        assert (valid_cycles == 1) else begin
            fails++;
            $error("FAIL key3_pulse observed=%0d expected=1", valid_cycles);
        end
        release_keys("key3_release");
        total++;
        assert (code_out === 4'd3) else begin
            fails++;
            $error("FAIL key3_code_held observed=%0d expected=3", code_out);
        end

        // Key 7 bouncing for 6 clocks, then held.
        clear_counts();
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 10'h080 : 10'h000, 1'b1, "bounce");
        total++;
        assert (valid_cycles == 0) else begin
            fails++;
            $error("FAIL bounce_quiet observed=%0d expected=0", valid_cycles);
        end
        for (int i = 0; i < 12; i++) step(10'h080, 1'b1, "key7");
        release_keys("key7_release");
        total++;
        assert (valid_cycles == 1 && code_out === 4'd7) else begin
            fails++;
            $error("FAIL key7_once observed=%0d/%0d expected=1/7", valid_cycles, code_out);
        end

        // Key 9 under backpressure; key 1 pressed meanwhile must not disturb it.
        clear_counts();
        for (int i = 0; i < 8; i++) step(10'h200, 1'b0, "key9");
        for (int i = 0; i < 10; i++) begin
            step(10'h002, 1'b0, "key9_hold");
            total++;
            assert (valid === 1'b1 && code_out === 4'd9) else begin
                fails++;
                $error("FAIL key9_hold observed=%0b/%0d expected=1/9", valid, code_out);
            end
        end
        step(10'h002, 1'b1, "key9_ack");
        total++;
        assert (valid === 1'b0) else begin
            fails++;
            $error("FAIL key9_ack observed=%0b expected=0", valid);
        end
        release_keys("key9_release");

        // Keys 2 and 5 together.
        clear_counts();
        for (int i = 0; i < 10; i++) step(10'h024, 1'b1, "two_keys");
        release_keys("two_keys_release");
`ifdef DECIMAL_KEY_MULTI_ERR_EN
        total++;
        assert (err_cycles == 1 && valid_cycles == 0) else begin
            fails++;
            $error("FAIL two_keys_err observed=%0d/%0d expected=1/0", err_cycles, valid_cycles);
        end
`else
        total++;
        assert (valid_cycles == 1 && err_cycles == 0 && code_out === 4'd2) else begin
            fails++;
            $error("FAIL two_keys_prio observed=%0d/%0d/%0d expected=1/0/2",
                   valid_cycles, err_cycles, code_out);
        end
`endif

        // Reset while key 6 waits in EMIT.
        for (int i = 0; i < 8; i++) step(10'h040, 1'b0, "key6");
        #2;
        rst_n = 1'b0;
        f_in  = '0;
        model_reset();
        #1;
        check("reset_mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_counts();
        release_keys("after_reset");
        total++;
        assert (valid_cycles == 0) else begin
            fails++;
            $error("FAIL after_reset_spurious observed=%0d expected=0", valid_cycles);
        end

        // Key 0 encodes to 0000 and is told apart from idle only by valid.
        for (int i = 0; i < 8; i++) step(10'h001, 1'b0, "key0");
        total++;
        assert (valid === 1'b1 && code_out === 4'd0) else begin
            fails++;
            $error("FAIL key0 observed=%0b/%0d expected=1/0", valid, code_out);
        end
        step(10'h001, 1'b1, "key0_ack");
        release_keys("key0_release");

        // Random key traffic with random backpressure.
        for (int seg = 0; seg < 200; seg++) begin
            kind   = int'($urandom_range(0, 9));
            bounce = 1'b0;
            if (kind <= 2) pat = '0;
            else if (kind <= 7) pat = 10'(1 << $urandom_range(0, 9));
            else if (kind == 8) pat = 10'($urandom);
            else begin
                pat    = 10'(1 << $urandom_range(0, 9));
                bounce = 1'b1;
            end
            hold = int'($urandom_range(1, 10));
            for (int i = 0; i < hold; i++) begin
                f = (bounce && $urandom_range(0, 1) == 0) ? 10'h000 : pat;
                step(f, ($urandom_range(0, 3) != 0), "random");
            end
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
